reg_write_arbiter: RTL and testbench

//  Round-robin write arbiter that shares one load-enable N-bit register (RegisterNbit) among REQS requesters.

---
 rtl/reg_write_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter that shares a single load-enable
// N-bit register among REQS requesters. A winner's data is captured, presented
// on reg_D with a one-cycle reg_L/ack pulse, then HOLD_CYCLES quiet cycles
// follow before the next grant.
// Optional feature macro: ARB_LAST_ID_EN (adds last_id output).
module reg_write_arbiter #(
  parameter int N           = 8,
  parameter int REQS        = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clock,
  input  logic              R,
  input  logic [REQS-1:0]   req,
  input  logic [REQS*N-1:0] data,
  output logic [REQS-1:0]   ack,
  output logic [N-1:0]      reg_D,
  output logic              reg_L,
`ifdef ARB_LAST_ID_EN
  output logic [2:0]        last_id,
`endif
  output logic              busy
);

  localparam int PW = $clog2(REQS);
  localparam logic [3:0] HOLD_LAST = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q, sel_q, sel_d;
  logic            hit_d;
  logic [3:0]      hold_cnt_q;
  logic [REQS-1:0] ack_q;
  logic [N-1:0]    reg_D_q;
  logic            reg_L_q, busy_q;
  logic [N-1:0]    words [REQS];
  int              idx;
`ifdef ARB_LAST_ID_EN
  logic [2:0]      last_id_q;
  assign last_id = last_id_q;
`endif

  // Unpack the flat data bus into per-requester words.
  for (genvar g = 0; g < REQS; g++) begin : g_words
    assign words[g] = data[g*N +: N];
  end

  // Rotating-priority pick: first requester at or after ptr, wrapping.
  always_comb begin
    sel_d = '0;
    hit_d = 1'b0;
    idx   = 0;
    for (int i = 0; i < REQS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= REQS) idx = idx - REQS;
      if (!hit_d && req[PW'(idx)]) begin
        hit_d = 1'b1;
        sel_d = PW'(idx);
      end
    end
  end

  // Arbiter FSM; every output is a register so the load pulse is glitch-free.
  always_ff @(posedge clock) begin
    if (R) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      hold_cnt_q <= '0;
      ack_q      <= '0;
      reg_D_q    <= '0;
      reg_L_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_LAST_ID_EN
      last_id_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_d) begin
            // Data is sampled only here; later changes cannot alter the write.
            reg_D_q <= words[sel_d];
            sel_q   <= sel_d;
            ack_q   <= REQS'(1) << sel_d;
            reg_L_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LOAD;
`ifdef ARB_LAST_ID_EN
            last_id_q <= 3'(sel_d);
`endif
          end
        end
        LOAD: begin
          reg_L_q <= 1'b0;
          ack_q   <= '0;
          ptr_q   <= (sel_q == PW'(REQS - 1)) ? '0 : PW'(sel_q + 1'b1);
          if (HOLD_CYCLES > 0) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          reg_L_q <= 1'b0;
          ack_q   <= '0;
        end
      endcase
    end
  end

  assign ack   = ack_q;
  assign reg_D = reg_D_q;
  assign reg_L = reg_L_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: timeline model for the HOLD_CYCLES=2 instance,
// hand-computed expectations for both that and a HOLD_CYCLES=0 instance.
module tb_reg_write_arbiter;
  localparam int N = 8, REQS = 4, H = 2;

  logic        clock = 1'b0;
  logic        R;
  logic [3:0]  req, req0;
  logic [31:0] data, data0;
  logic [3:0]  ack, ack0;
  logic [7:0]  reg_D, reg_D0;
  logic        reg_L, reg_L0, busy, busy0;
`ifdef ARB_LAST_ID_EN
  logic [2:0]  last_id, last_id0;
`endif

  always #5 clock = ~clock;

  reg_write_arbiter #(.N(N), .REQS(REQS), .HOLD_CYCLES(H)) u_dut (
    .clock(clock), .R(R), .req(req), .data(data), .ack(ack), .reg_D(reg_D),
    .reg_L(reg_L),
`ifdef ARB_LAST_ID_EN
    .last_id(last_id),
`endif
    .busy(busy));

  reg_write_arbiter #(.N(N), .REQS(REQS), .HOLD_CYCLES(0)) u_dut0 (
    .clock(clock), .R(R), .req(req0), .data(data0), .ack(ack0), .reg_D(reg_D0),
    .reg_L(reg_L0),
`ifdef ARB_LAST_ID_EN
    .last_id(last_id0),
`endif
    .busy(busy0));

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] a);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (a[i]) r = i;
    return r;
  endfunction

  // Timeline model: a grant may happen at edge cyc only if cyc >= free_at;
  // each grant blocks the arbiter for 2+H edges and advances the pointer.
  int         cyc = 0, free_at = 0, mptr = 0;
  logic [3:0] m_ack;
  logic [7:0] m_D;
  logic       m_L, m_busy;
  logic [2:0] m_last;
  bit         mvalid = 0;
  logic       prevL0 = 1'b0;

  always @(posedge clock) begin
    int sel;
    sel = -1;
    cyc++;
    if (R) begin
      m_ack = 0; m_L = 0; m_D = 0; m_busy = 0; mptr = 0; m_last = 0;
      free_at = cyc + 1;
    end else begin
      m_ack = 0; m_L = 0;
      if (cyc >= free_at && req != 0) begin
        for (int j = 0; j < REQS; j++)
          if (sel < 0 && req[(mptr + j) % REQS]) sel = (mptr + j) % REQS;
        m_D     = data[sel*N +: N];
        m_L     = 1;
        m_ack   = 4'(1 << sel);
        m_last  = 3'(sel);
        mptr    = (sel + 1) % REQS;
        free_at = cyc + 2 + H;
      end
      m_busy = (cyc < free_at - 1);
    end
    mvalid = 1;
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clock) begin
    if (mvalid) begin
      chk("ack", ack, m_ack);
      chk("reg_L", reg_L, m_L);
      chk("reg_D", reg_D, m_D);
      chk("busy", busy, m_busy);
`ifdef ARB_LAST_ID_EN
      chk("last_id", last_id, m_last);
`endif
      chk("h0_reg_L_back_to_back", reg_L0 & prevL0, 0);
      chk("h0_ack_without_L", (ack0 != 0) && !reg_L0, 0);
      prevL0 = reg_L0;
    end
  end

  int         n, gid[5], gcyc[5];
  logic [3:0] dropped;
  int         ord[5]      = '{0, 1, 2, 3, 0};
  logic [3:0] t6_ack[6]   = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
  logic [7:0] t6_D[6]     = '{8'hB0, 8'hB0, 8'hB1, 8'hB1, 8'hB0, 8'hB0};
  logic [2:0] t6_id[6]    = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};

  initial begin
    R = 1; req = 0; data = 0; req0 = 0; data0 = 0;
    tick(); tick();
    R = 0;

    // 1: idle after reset
    repeat (10) tick();
    chk("t1_reg_D", reg_D, 0);
    chk("t1_busy", busy, 0);
    chk("t1_reg_L", reg_L, 0);

    // 2: single write from requester 2
    req = 4'b0100; data[16 +: 8] = 8'hA5;
    tick();
    chk("t2_reg_L", reg_L, 1);
    chk("t2_ack", ack, 4'b0100);
    chk("t2_reg_D", reg_D, 8'hA5);
    req = 0;
    tick(); chk("t2_busy_hold1", busy, 1); chk("t2_L_low", reg_L, 0);
    tick(); chk("t2_busy_hold2", busy, 1);
    tick(); chk("t2_busy_idle", busy, 0);

    // 3: round-robin from a fresh pointer, requesters re-raise after ack
    R = 1; tick(); R = 0;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'hF; dropped = 0; n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      req = req | dropped;
      dropped = ack;
      req = req & ~ack;
      if (ack != 0) begin
        gid[n] = idx_of(ack);
        gcyc[n] = c;
        chk("t3_reg_D", reg_D, 8'h10 + 8'(ord[n]));
        n++;
      end
    end
    req = 0;
    chk("t3_grants", n, 5);
    for (int i = 0; i < n; i++) chk("t3_order", gid[i], ord[i]);
    for (int i = 1; i < n; i++) chk("t3_spacing", gcyc[i] - gcyc[i-1], 4);
    repeat (4) tick();

    // 4: data change during LOAD does not affect the write
    data[8 +: 8] = 8'h11; req = 4'b0010;
    tick();
    chk("t4_ack", ack, 4'b0010);
    data[8 +: 8] = 8'h22; req = 0;
    tick(); chk("t4_reg_D_load", reg_D, 8'h11);
    repeat (3) tick();
    chk("t4_reg_D_held", reg_D, 8'h11);
    chk("t4_busy", busy, 0);

    // 5: reset in the first HOLD cycle, pending requester 3
    req = 4'b0001;
    tick(); chk("t5_ack0", ack, 4'b0001);
    req = 4'b1000;
    tick(); chk("t5_in_hold", busy, 1);
    R = 1;
    tick(); chk("t5_busy_rst", busy, 0); chk("t5_L_rst", reg_L, 0);
    R = 0;
    tick(); chk("t5_ack3", ack, 4'b1000); chk("t5_reg_D", reg_D, 8'h13);
    req = 0;
    repeat (4) tick();

    // reset during LOAD clears the pointer advance
    req = 4'b0001;
    tick(); chk("tl_ack0", ack, 4'b0001);
    R = 1; req = 0;
    tick(); chk("tl_ack_rst", ack, 0); chk("tl_busy_rst", busy, 0); chk("tl_reg_D_rst", reg_D, 0);
    R = 0; req = 4'b0011;
    tick(); chk("tl_ptr0", ack, 4'b0001);
    req = 0;
    repeat (4) tick();

    // 6: HOLD_CYCLES=0 instance, continuous requests from 0 and 1
    data0 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    req0 = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_reg_L", reg_L0, t6_ack[i] != 0);
      chk("t6_ack", ack0, t6_ack[i]);
      chk("t6_reg_D", reg_D0, t6_D[i]);
      chk("t6_busy", busy0, t6_ack[i] != 0);
`ifdef ARB_LAST_ID_EN
      chk("t6_last_id", last_id0, t6_id[i]);
`endif
    end
    req0 = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
